// File: rtl/comp_bist_pkg.sv
// comp_pkg: FSM states and response encoding for the comparator self-test.
package comp_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam logic [2:0] RESP_GT = 3'b100;
  localparam logic [2:0] RESP_LT = 3'b010;
  localparam logic [2:0] RESP_EQ = 3'b001;
endpackage

// File: rtl/comp_bist_if.sv
// comp_bist_if: stimulus/response bundle between the BIST engine and the comparator under test.
// COMP_BIST_FAIL_LOG_EN adds the first-failure capture signals.
interface comp_bist_if #(parameter int WIDTH = 2);
  logic start, greater_in, lesser_in, equal_in, busy, done, pass;
  logic [WIDTH-1:0] a_out, b_out;
  logic [2*WIDTH:0] err_count;
`ifdef COMP_BIST_FAIL_LOG_EN
  logic fail_valid;
  logic [WIDTH-1:0] fail_a, fail_b;
  logic [2:0] fail_resp;
`endif
  modport master(
    input start, greater_in, lesser_in, equal_in,
    output a_out, b_out, busy, done, pass, err_count
`ifdef COMP_BIST_FAIL_LOG_EN
    , output fail_valid, fail_a, fail_b, fail_resp
`endif
  );
  modport slave(
    output start, greater_in, lesser_in, equal_in,
    input a_out, b_out, busy, done, pass, err_count
`ifdef COMP_BIST_FAIL_LOG_EN
    , input fail_valid, fail_a, fail_b, fail_resp
`endif
  );
endinterface

// File: rtl/comp_bist_ref.sv
// comp_ref: golden unsigned comparator used as the expected-response generator.
module comp_ref #(parameter int WIDTH = 2) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             lesser,
  output logic             equal
);
  assign greater = a > b;
  assign lesser  = a < b;
  assign equal   = a == b;
endmodule

// File: rtl/comp_bist.sv
// comp_bist: exhaustive a-major/b-minor sweep of a WIDTH-bit comparator with error counting.
// COMP_BIST_FAIL_LOG_EN enables capture of the first mismatching vector and response.
module comp_bist
  import comp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input logic       clk,
  input logic       rst,
  comp_bist_if.master bus
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int EW = 2*WIDTH+1;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic [EW-1:0] r_err, w_err;
  logic [2:0] w_resp, w_exp;
  logic r_pass, w_g, w_l, w_e, w_miss, w_last, w_settled;
`ifdef COMP_BIST_FAIL_LOG_EN
  logic r_fv;
  logic [WIDTH-1:0] r_fa, r_fb;
  logic [2:0] r_fr;
  assign bus.fail_valid = r_fv;
  assign bus.fail_a     = r_fa;
  assign bus.fail_b     = r_fb;
  assign bus.fail_resp  = r_fr;
`endif
  comp_ref #(.WIDTH(WIDTH)) u_ref (.a(r_a), .b(r_b), .greater(w_g), .lesser(w_l), .equal(w_e));
  assign w_resp    = {bus.greater_in, bus.lesser_in, bus.equal_in};
  assign w_exp     = w_g ? RESP_GT : w_l ? RESP_LT : RESP_EQ;
  assign w_miss    = w_resp != w_exp;
  assign w_last    = &{r_a, r_b};
  assign w_settled = r_cnt == CW'(SETTLE-1);
  assign w_err     = (w_miss && !(&r_err)) ? r_err + 1'b1 : r_err;
  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next   = (r_state == IDLE)  ? (bus.start ? DRIVE : IDLE) :
               (r_state == DRIVE) ? (w_settled ? CHECK : DRIVE) :
               (r_state == CHECK) ? (w_last ? DONE : DRIVE) : IDLE;
    bus.busy = (r_state == DRIVE) || (r_state == CHECK);
    bus.done = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
`ifdef COMP_BIST_FAIL_LOG_EN
      r_fv   <= 1'b0;
      r_fa   <= '0;
      r_fb   <= '0;
      r_fr   <= '0;
`endif
    end else if (r_state == IDLE && bus.start) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
`ifdef COMP_BIST_FAIL_LOG_EN
      r_fv   <= 1'b0;
      r_fa   <= '0;
      r_fb   <= '0;
      r_fr   <= '0;
`endif
    end else if (r_state == DRIVE) begin
      r_cnt <= w_settled ? '0 : r_cnt + 1'b1;
    end else if (r_state == CHECK) begin
      r_err <= w_err;
      // pass uses the updated count so the final vector is included
      if (w_last) r_pass <= w_err == '0;
      else {r_a, r_b} <= {r_a, r_b} + 1'b1;
`ifdef COMP_BIST_FAIL_LOG_EN
      if (w_miss && !r_fv) begin
        r_fv <= 1'b1;
        r_fa <= r_a;
        r_fb <= r_b;
        r_fr <= w_resp;
      end
`endif
    end
  end
endmodule

// File: tb/tb_comp_bist.sv
// tb_comp_bist: directed checks of comp_bist with a scoreboard of expected sweep outcomes.
module tb_comp_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  comp_bist_if #(.WIDTH(2)) bus ();
  comp_bist_if #(.WIDTH(3)) bus3 ();
  comp_bist #(.WIDTH(2), .SETTLE(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  comp_bist #(.WIDTH(3), .SETTLE(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int err; bit pass; int fa; int fb; int fr;} exp_t;
  exp_t sb[$];
  // comparator under test: 0 correct, 1 equal stuck at 0, 2 greater/lesser swapped
  always_comb begin
    bus.greater_in = (mode == 2) ? (bus.a_out < bus.b_out) : (bus.a_out > bus.b_out);
    bus.lesser_in  = (mode == 2) ? (bus.a_out > bus.b_out) : (bus.a_out < bus.b_out);
    bus.equal_in   = (mode == 1) ? 1'b0 : (bus.a_out == bus.b_out);
  end
  assign bus3.greater_in = 1'b0;
  assign bus3.lesser_in  = 1'b0;
  assign bus3.equal_in   = 1'b0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic sweep(input int m, input bit hold);
    exp_t e;
    exp_t r;
    logic [2:0] got, want;
    e = '{err: 0, pass: 1'b0, fa: 0, fb: 0, fr: 0};
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        want = {a > b, a < b, a == b};
        got  = (m == 2) ? {a < b, a > b, a == b} : (m == 1) ? {a > b, a < b, 1'b0} : want;
        if (got != want) begin
          if (e.err == 0) begin
            e.fa = a;
            e.fb = b;
            e.fr = int'(got);
          end
          e.err++;
        end
      end
    e.pass = e.err == 0;
    sb.push_back(e);
    mode = m;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) bus.start = 1'b0;
      if (n <= 32) begin
        check("a_out", bus.a_out, ((n-1)/2)/4);
        check("b_out", bus.b_out, ((n-1)/2)%4);
        check("busy", bus.busy, 1);
        check("pass_cleared", bus.pass, 0);
      end
      check("done", bus.done, n == 33);
    end
    r = sb.pop_front();
    check("err_count", bus.err_count, r.err);
    check("pass", bus.pass, r.pass);
    check("busy_done", bus.busy, 0);
`ifdef COMP_BIST_FAIL_LOG_EN
    check("fail_valid", bus.fail_valid, r.err != 0);
    if (r.err != 0) begin
      check("fail_a", bus.fail_a, r.fa);
      check("fail_b", bus.fail_b, r.fb);
      check("fail_resp", bus.fail_resp, r.fr);
    end
`endif
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    @(negedge clk);
    check("rst_a", bus.a_out, 0);
    check("rst_b", bus.b_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_err", bus.err_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wait", bus.busy, 0);
    sweep(0, 1'b0);
    @(negedge clk);
    check("hold_a", bus.a_out, 3);
    check("hold_b", bus.b_out, 3);
    check("hold_pass", bus.pass, 1);
    check("hold_done", bus.done, 0);
    sweep(1, 1'b0);
    @(negedge clk);
    sweep(2, 1'b0);
    @(negedge clk);
    // asynchronous reset mid-sweep, asserted between clock edges
    mode = 0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_pass", bus.pass, 0);
    check("arst_err", bus.err_count, 0);
    check("arst_a", bus.a_out, 0);
    check("arst_b", bus.b_out, 0);
`ifdef COMP_BIST_FAIL_LOG_EN
    check("arst_fail_valid", bus.fail_valid, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bus.busy, 0);
    sweep(0, 1'b0);
    @(negedge clk);
    // start held high: one sweep, then re-accept only from IDLE after done
    sweep(0, 1'b1);
    @(negedge clk);
    check("held_idle_busy", bus.busy, 0);
    check("held_idle_pass", bus.pass, 1);
    @(negedge clk);
    check("held_restart_busy", bus.busy, 1);
    check("held_restart_pass", bus.pass, 0);
    check("held_restart_a", bus.a_out, 0);
    for (int k = 36; k <= 67; k++) begin
      @(negedge clk);
      if (k == 40) bus.start = 1'b0;
      check("held_done", bus.done, k == 67);
    end
    check("held_pass", bus.pass, 1);
    check("held_err", bus.err_count, 0);
    @(negedge clk);
    // WIDTH=3, SETTLE=2 with all responses 0
    bus3.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.start = 1'b0;
    n = 1;
    while (!bus3.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("w3_latency", n, 193);
    check("w3_err", bus3.err_count, 64);
    check("w3_pass", bus3.pass, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
